// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD,
        DONE
    } arb_state_e;

    typedef enum logic {
        PORT_I,
        PORT_D
    } arb_port_e;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return |(addr_lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between the instruction-fetch and data ports,
// sequencing cs/we and returning a one-cycle ack with registered read data.
//
// state  | meaning
// IDLE   | arbitrate; latch winner's port, we, addr, wdata
// ACCESS | first memory cycle (cs=1, we=latched we)
// HOLD   | loads only: re-read same word, capture rdata at end of cycle
// DONE   | ack cycle for the winner; requests are not sampled
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int width        = 32,
    parameter int starve_limit = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             i_req,
    input  logic [width-1:0] i_addr,
    output logic             i_ack,
    output logic [width-1:0] i_rdata,
    output logic             i_err,

    input  logic             d_req,
    input  logic             d_we,
    input  logic [width-1:0] d_addr,
    input  logic [width-1:0] d_wdata,
    output logic             d_ack,
    output logic [width-1:0] d_rdata,
    output logic             d_err,

    output logic             mem_cs,
    output logic             mem_we,
    output logic [width-1:0] mem_addr,
    output logic [width-1:0] mem_wdata,
    input  logic [width-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(starve_limit);

    arb_state_e       state_q, state_d;
    arb_port_e        port_q, port_d;
    logic [3:0]       streak_q, streak_d;
    logic             mem_cs_q, mem_cs_d;
    logic             mem_we_q, mem_we_d;
    logic [width-1:0] mem_addr_q, mem_addr_d;
    logic [width-1:0] mem_wdata_q, mem_wdata_d;
    logic             i_ack_q, i_ack_d;
    logic             d_ack_q, d_ack_d;
    logic             i_err_q, i_err_d;
    logic             d_err_q, d_err_d;
    logic [width-1:0] i_rdata_q, i_rdata_d;
    logic [width-1:0] d_rdata_q, d_rdata_d;

    logic             grant_i;
    logic [width-1:0] sel_addr;
    logic             sel_err;

    always_comb begin
        // Data port wins unless the instruction port has been passed over starve_limit times.
        grant_i  = i_req && (!d_req || (streak_q == LIMIT));
        sel_addr = grant_i ? i_addr : d_addr;
        sel_err  = is_misaligned(sel_addr[1:0]);

        state_d     = state_q;
        port_d      = port_q;
        streak_d    = streak_q;
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        d_err_d     = 1'b0;
        i_rdata_d   = '0;
        d_rdata_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (!i_req) begin
                    streak_d = '0;
                end
                if (i_req || d_req) begin
                    port_d     = grant_i ? PORT_I : PORT_D;
                    mem_addr_d = sel_addr;
                    if (grant_i) begin
                        streak_d = '0;
                    end else begin
                        mem_wdata_d = d_wdata;
                        if (i_req && (streak_q != LIMIT)) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end
                    if (sel_err) begin
                        state_d = DONE;
                        i_ack_d = grant_i;
                        d_ack_d = !grant_i;
                        i_err_d = grant_i;
                        d_err_d = !grant_i;
                    end else begin
                        state_d  = ACCESS;
                        mem_cs_d = 1'b1;
                        mem_we_d = !grant_i && d_we;
                    end
                end
            end
            ACCESS: begin
                // mem_we_q still holds the latched we during ACCESS.
                if (mem_we_q) begin
                    state_d = DONE;
                    i_ack_d = (port_q == PORT_I);
                    d_ack_d = (port_q == PORT_D);
                end else begin
                    state_d  = HOLD;
                    mem_cs_d = 1'b1;
                end
            end
            HOLD: begin
                state_d = DONE;
                if (port_q == PORT_I) begin
                    i_ack_d   = 1'b1;
                    i_rdata_d = mem_rdata;
                end else begin
                    d_ack_d   = 1'b1;
                    d_rdata_d = mem_rdata;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            port_q      <= PORT_I;
            streak_q    <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            streak_q    <= streak_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_err_q     <= i_err_d;
            d_err_q     <= d_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model
// and a simple registered-read word memory.
module tb_mem_arbiter;

    localparam int W      = 32;
    localparam int STARVE = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_req = 1'b0;
    logic [W-1:0] i_addr = '0;
    logic         i_ack;
    logic [W-1:0] i_rdata;
    logic         i_err;
    logic         d_req = 1'b0;
    logic         d_we = 1'b0;
    logic [W-1:0] d_addr = '0;
    logic [W-1:0] d_wdata = '0;
    logic         d_ack;
    logic [W-1:0] d_rdata;
    logic         d_err;
    logic         mem_cs;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // Memory model: 64 words, registered read, backdoor load port for preloading.
    logic [W-1:0] mem [0:63];
    logic [W-1:0] rd_q = '0;
    logic         bd_we = 1'b0;
    logic [5:0]   bd_idx = '0;
    logic [W-1:0] bd_data = '0;
    logic [W-1:0] ref_mem [0:63];

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (mem_cs && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_cs && !mem_we) rd_q <= mem[mem_addr[7:2]];
    end
    // A junk pattern stands in for the undriven bus while cs is low.
    assign mem_rdata = mem_cs ? rd_q : 32'hBAD0_BAD0;

    always #5 clk = ~clk;

    mem_arbiter #(.width(W), .starve_limit(STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_mem_cs"}, mem_cs, 1'b0);
        check1({tag, "_mem_we"}, mem_we, 1'b0);
        check1({tag, "_i_ack"}, i_ack, 1'b0);
        check1({tag, "_d_ack"}, d_ack, 1'b0);
        check1({tag, "_i_err"}, i_err, 1'b0);
        check1({tag, "_d_err"}, d_err, 1'b0);
        check32({tag, "_mem_addr"}, mem_addr, 32'h0);
        check32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check32({tag, "_i_rdata"}, i_rdata, 32'h0);
        check32({tag, "_d_rdata"}, d_rdata, 32'h0);
    endtask

    // Called with the arbiter in IDLE; returns with it back in IDLE and requests low.
    task automatic access(input bit use_i, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int cs_n,
                          output logic [31:0] rdata, output logic err);
        if (use_i) begin
            i_req = 1'b1; i_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end
        lat = 0; cs_n = 0;
        do begin
            tick();
            lat++;
            if (mem_cs) cs_n++;
        end while (!(use_i ? i_ack : d_ack) && lat < 16);
        rdata = use_i ? i_rdata : d_rdata;
        err   = use_i ? i_err : d_err;
        i_req = 1'b0; d_req = 1'b0;
        tick();
        check1("ack_one_cycle", use_i ? i_ack : d_ack, 1'b0);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    int t, idle_at, ack_at, cs_lo, cs_hi, streak, lat, csn, n, guard, mlat;
    bit m_i, m_we, m_err, pend_i, pend_d, both;
    logic [31:0] m_addr, m_wdata, m_rdata, rd;
    logic er;
    logic [9:0] order;

    initial begin
        // Reset and preload.
        rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        for (int k = 0; k < 64; k++) begin
            bd_we = 1'b1;
            bd_idx = 6'(k);
            bd_data = (k == 0) ? 32'h2008_0005 : $urandom;
            ref_mem[k] = bd_data;
            tick();
        end
        bd_we = 1'b0;
        check_reset_outputs("reset_held");
        rst_n = 1'b1;

        // Store then load back.
        access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, csn, rd, er);
        ref_mem[4] = 32'hDEAD_BEEF;
        check32("store_latency", 32'(lat), 32'd2);
        check32("store_rdata", rd, 32'h0);
        check1("store_err", er, 1'b0);
        check32("store_cs_cycles", 32'(csn), 32'd1);

        access(1'b0, 1'b0, 32'h10, 32'h0, lat, csn, rd, er);
        check32("load_latency", 32'(lat), 32'd3);
        check32("load_rdata", rd, 32'hDEAD_BEEF);
        check1("load_err", er, 1'b0);
        check32("load_cs_cycles", 32'(csn), 32'd2);

        // Instruction fetch of preloaded word.
        access(1'b1, 1'b0, 32'h0, 32'h0, lat, csn, rd, er);
        check32("ifetch_latency", 32'(lat), 32'd3);
        check32("ifetch_rdata", rd, 32'h2008_0005);
        check1("ifetch_err", er, 1'b0);

        // Misaligned load.
        access(1'b0, 1'b0, 32'h13, 32'h0, lat, csn, rd, er);
        check32("misalign_latency", 32'(lat), 32'd1);
        check1("misalign_err", er, 1'b1);
        check32("misalign_rdata", rd, 32'h0);
        check32("misalign_cs_cycles", 32'(csn), 32'd0);

        // Both ports requesting continuously: fairness pattern.
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        n = 0; guard = 0; both = 1'b0; order = '0;
        while (n < 10 && guard < 200) begin
            tick();
            guard++;
            if (i_ack && d_ack) both = 1'b1;
            if (i_ack || d_ack) begin
                order = {order[8:0], i_ack};
                n++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        check32("grant_count", 32'(n), 32'd10);
        check32("grant_order", 32'(order), 32'(10'b00001_00001));
        check1("no_double_ack", both, 1'b0);

        // Requester changes address and data while its store is in flight.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D;
        tick();
        check1("chg_cs", mem_cs, 1'b1);
        check32("chg_mem_addr", mem_addr, 32'h20);
        check32("chg_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        d_addr = 32'h24; d_wdata = 32'h1111_1111;
        tick();
        check1("chg_ack", d_ack, 1'b1);
        d_req = 1'b0;
        tick();
        ref_mem[8] = 32'hCAFE_F00D;
        access(1'b0, 1'b0, 32'h20, 32'h0, lat, csn, rd, er);
        check32("chg_readback_orig", rd, 32'hCAFE_F00D);
        access(1'b0, 1'b0, 32'h24, 32'h0, lat, csn, rd, er);
        check32("chg_readback_other", rd, ref_mem[9]);

        // Reset pulsed during HOLD.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        tick();
        tick();
        check1("hold_cs", mem_cs, 1'b1);
        d_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        for (int k = 0; k < 3; k++) begin
            tick();
            check1("rst_no_ack", d_ack, 1'b0);
        end
        rst_n = 1'b1;
        access(1'b0, 1'b0, 32'h10, 32'h0, lat, csn, rd, er);
        check32("post_rst_latency", 32'(lat), 32'd3);
        check32("post_rst_rdata", rd, 32'hDEAD_BEEF);

        // Randomized traffic against the transaction-level model.
        t = 0; idle_at = 0; ack_at = -1; cs_lo = -10; cs_hi = -10; streak = 0;
        m_i = 1'b0; m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        pend_i = 1'b0; pend_d = 1'b0;
        repeat (600) begin
            check1("rnd_i_ack", i_ack, (t == ack_at) && m_i);
            check1("rnd_d_ack", d_ack, (t == ack_at) && !m_i);
            check1("rnd_mem_cs", mem_cs, (t >= cs_lo) && (t <= cs_hi));
            if (t >= cs_lo && t <= cs_hi) begin
                check32("rnd_mem_addr", mem_addr, m_addr);
                check1("rnd_mem_we", mem_we, m_we && (t == cs_lo));
                if (m_we) check32("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            if (t == ack_at) begin
                if (m_i) begin
                    check32("rnd_i_rdata", i_rdata, m_rdata);
                    check1("rnd_i_err", i_err, m_err);
                    if (pend_i) begin pend_i = 1'b0; i_req = 1'b0; end
                end else begin
                    check32("rnd_d_rdata", d_rdata, m_rdata);
                    check1("rnd_d_err", d_err, m_err);
                    if (pend_d) begin pend_d = 1'b0; d_req = 1'b0; end
                end
            end

            if (!pend_i && !(m_i && t < ack_at) && $urandom_range(0, 2) == 0) begin
                pend_i = 1'b1; i_req = 1'b1; i_addr = rnd_addr();
            end else if (pend_i && $urandom_range(0, 7) == 0) begin
                i_addr = rnd_addr();
            end else if (pend_i && $urandom_range(0, 19) == 0) begin
                pend_i = 1'b0; i_req = 1'b0;
            end
            if (!pend_d && !(!m_i && t < ack_at) && $urandom_range(0, 1) == 0) begin
                pend_d = 1'b1; d_req = 1'b1; d_addr = rnd_addr();
                d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end else if (pend_d && $urandom_range(0, 7) == 0) begin
                d_addr = rnd_addr(); d_wdata = $urandom;
            end else if (pend_d && $urandom_range(0, 19) == 0) begin
                pend_d = 1'b0; d_req = 1'b0;
            end

            if (t == idle_at) begin
                if (!i_req) streak = 0;
                if (i_req || d_req) begin
                    if (d_req && !(i_req && streak == STARVE)) m_i = 1'b0;
                    else m_i = 1'b1;
                    if (m_i) streak = 0;
                    else if (i_req) streak = (streak < STARVE) ? streak + 1 : STARVE;
                    m_addr  = m_i ? i_addr : d_addr;
                    m_we    = m_i ? 1'b0 : d_we;
                    m_wdata = d_wdata;
                    m_err   = (m_addr % 4) != 0;
                    mlat    = m_err ? 1 : (m_we ? 2 : 3);
                    ack_at  = t + mlat;
                    idle_at = ack_at + 1;
                    cs_lo   = m_err ? -10 : t + 1;
                    cs_hi   = m_err ? -10 : t + mlat - 1;
                    m_rdata = '0;
                    if (!m_err && m_we) ref_mem[m_addr / 4] = m_wdata;
                    else if (!m_err) m_rdata = ref_mem[m_addr / 4];
                end else begin
                    idle_at = t + 1;
                end
            end
            tick();
            t++;
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port word memory between the instruction-fetch port and the data (load/store) port of the CPU. It sequences each access through the memory's chip-select/write-enable protocol and holds read data stable until capture. It returns a one-cycle acknowledge with registered read data to the winning requester. It sits between the pipeline's IF/MEM stages and the memory instance, and is the only driver of the memory's `cs`, `we`, `addr_i` and `data_i` inputs.

## Interface
- `width`, 32: data and byte-address width.
- `starve_limit`, 4: maximum consecutive data-port grants while an instruction request is pending; range 1..15.

- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: instruction read request, held until `i_ack`.
- `i_addr` in width: instruction byte address.
- `i_ack` out 1: one-cycle completion pulse.
- `i_rdata` out width: fetched word, valid while `i_ack`=1.
- `i_err` out 1: misaligned address, valid while `i_ack`=1.
- `d_req` in 1: data request, held until `d_ack`.
- `d_we` in 1: 1=store, 0=load.
- `d_addr` in width: data byte address.
- `d_wdata` in width: store data.
- `d_ack`, `d_rdata`, `d_err` out 1/width/1: as for the instruction port.
- `mem_cs`, `mem_we` out 1: memory chip select / write enable.
- `mem_addr`, `mem_wdata` out width: memory byte address / write data.
- `mem_rdata` in width: memory registered read data; high-Z when cs is low.

## Operation
- FSM states: IDLE, ACCESS, HOLD, DONE. Arbitration is evaluated only in IDLE. DONE is the ack cycle and never samples requests.
- IDLE with any request: pick a winner and latch port, we, addr and wdata.
  - Selection order: data wins, except instruction wins when `i_req`=1 and streak == `starve_limit`.
  - IDLE → ACCESS; or IDLE → DONE with err=1 if `addr[1:0]`≠0 (no memory access).
- ACCESS: `mem_cs`=1, `mem_we`=latched we.
  - Store: ACCESS → DONE.
  - Load: ACCESS → HOLD.
- HOLD (load only): `mem_cs`=1, `mem_we`=0, same address. Memory re-reads the same word. Capture `mem_rdata` into the rdata register at the end of HOLD. HOLD → DONE.
- DONE: winner's ack=1 with registered rdata/err; `mem_cs`=0. DONE → IDLE.
- Store ack: `*_rdata`=0. Error ack: `*_rdata`=0, `*_err`=1.
- Streak counter (4 bits):
  - Increments on each data grant made while `i_req`=1.
  - Clears on any instruction grant, or when IDLE sees `i_req`=0.
  - Saturates at `starve_limit`.
- Requester changing addr/we/wdata while its req is high and unacked: the latched copy is used; the change is ignored.
- Req dropped before ack: the access still completes. The ack pulse is still issued and may be ignored.
- A new request in the cycle after ack is accepted normally.

## Timing
- Reset (async assert, sync release): state=IDLE; `mem_cs`, `mem_we`, `i_ack`, `d_ack`, `i_err`, `d_err`=0; `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata`=0; streak=0.
- Reset mid-access aborts the access without ack. A store in ACCESS may or may not land.
- All outputs are registered.
- Load latency: req high in IDLE cycle 0 → ACCESS 1 → HOLD 2 → ack+rdata in cycle 3.
- Store: ack in cycle 2. Misaligned: ack+err in cycle 1.
- Back-to-back throughput: load every 4 cycles, store every 3, error every 2.
- Simultaneous `i_req`/`d_req` in IDLE: the priority rule applies. The loser stays pending and is evaluated in the next IDLE.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/ACCESS/HOLD/DONE), port-select enum (PORT_I/PORT_D), alignment-mask constant.
- Single module. The streak counter and FSM stay inline; no sub-module.

## Test plan
- Reset, then `d_req`=1, `d_we`=1, `d_addr`=0x10, `d_wdata`=0xDEADBEEF → `d_ack` in cycle 2; then a load of 0x10 → `d_ack` in cycle 3 with `d_rdata`=0xDEADBEEF, `mem_cs` high exactly 2 cycles.
- `i_req` load of 0x0 (preloaded 0x20080005) → `i_ack` in cycle 3, `i_rdata`=0x20080005, `i_err`=0.
- `i_req` and `d_req` held high continuously, `starve_limit`=4 → grant order D,D,D,D,I,D,D,D,D,I.
- `d_addr`=0x13 load → `d_ack`=1 with `d_err`=1 and `d_rdata`=0 in cycle 1; `mem_cs` never asserted.
- `rst_n` pulsed low during HOLD → all outputs 0 immediately, no ack; the next request completes with normal latency.
- Requester changes `d_addr` during ACCESS → access uses the originally latched address.
